serial_deframer: RTL and testbench

- Sits directly downstream of the 1-bit ShiftRegister and consumes its serial `io_out` stream, one bit per clock.
- Detects a start bit, assembles DATA_W data bits LSB-first, and optionally checks a parity bit and the stop bit.
- Presents each good frame as a parallel word through a one-entry valid/ready output register.
- Reports parity, framing and overrun errors as one-cycle pulses.

---
 rtl/serial_deframer.sv | 144 ++++++++++++++
 tb/tb_serial_deframer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deframer.sv
// Serial deframer: start bit, DATA_W data bits LSB-first, optional parity, stop bit.
// Good frames go to a one-entry valid/ready output register; errors are one-cycle pulses.
module serial_deframer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PARITY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in,
  output logic [DATA_W-1:0] io_out_bits,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_busy,
  output logic              io_parity_err,
  output logic              io_frame_err,
  output logic              io_overrun
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 2);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DATA      = 3'd1;
  localparam logic [2:0] S_PAR       = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_fail_q, par_fail_d;
  logic [DATA_W-1:0] bits_q, bits_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              frame_ok_c;
  logic              drain_c;

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_fail_d = par_fail_q;
    bits_d     = bits_q;
    valid_d    = valid_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    frame_ok_c = 1'b0;
    drain_c    = valid_q && io_out_ready;

    case (state_q)
      S_IDLE: begin
        if (!io_in) begin
          state_d    = S_DATA;
          cnt_d      = '0;
          par_fail_d = 1'b0;
        end
      end
      S_DATA: begin
        for (int i = 0; i < int'(DATA_W); i++) begin
          if (cnt_q == CNT_W'(i)) shreg_d[i] = io_in;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = PAR_EN ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        par_fail_d = (io_in != ((^shreg_q) ^ PAR_ODD));
        state_d    = S_STOP;
      end
      S_STOP: begin
        if (io_in) begin
          state_d = S_IDLE;
          if (par_fail_q) perr_d = 1'b1;
          else            frame_ok_c = 1'b1;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // Line must return high before another start bit is accepted
        if (io_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_ok_c) begin
      if (!valid_q || io_out_ready) begin
        bits_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (drain_c) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == S_DATA) || (state_d == S_PAR) || (state_d == S_STOP);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_fail_q <= 1'b0;
      bits_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_fail_q <= par_fail_d;
      bits_q     <= bits_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign io_out_bits   = bits_q;
  assign io_out_valid  = valid_q;
  assign io_busy       = busy_q;
  assign io_parity_err = perr_q;
  assign io_frame_err  = ferr_q;
  assign io_overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: frame-level model feeds expected words/errors,
// a negedge monitor pops them as the DUT presents handshakes and error pulses.
module tb_serial_deframer;

  localparam int K_NONE = 0;
  localparam int K_GOOD = 1;
  localparam int K_PERR = 2;
  localparam int K_FERR = 3;
  localparam int K_OVR  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in;
  logic [7:0] io_out_bits;
  logic       io_out_valid;
  logic       io_out_ready;
  logic       io_busy;
  logic       io_parity_err;
  logic       io_frame_err;
  logic       io_overrun;

  logic       line5;
  logic       ready5;
  logic [4:0] bits5;
  logic       valid5, busy5, perr5, ferr5, ovr5;

  int         n_chk;
  int         n_pass;
  logic [7:0] word_q[$];
  int         err_q[$];
  bit         held;
  bit         prev_hold;
  logic [7:0] prev_bits;

  always #5 clock = ~clock;

  serial_deframer #(.DATA_W(8), .PARITY(1)) u_dut (
    .clock(clock), .reset(reset), .io_in(io_in),
    .io_out_bits(io_out_bits), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_busy(io_busy), .io_parity_err(io_parity_err), .io_frame_err(io_frame_err),
    .io_overrun(io_overrun)
  );

  serial_deframer #(.DATA_W(5), .PARITY(0)) u_dut5 (
    .clock(clock), .reset(reset), .io_in(line5),
    .io_out_bits(bits5), .io_out_valid(valid5), .io_out_ready(ready5),
    .io_busy(busy5), .io_parity_err(perr5), .io_frame_err(ferr5),
    .io_overrun(ovr5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic take_err(input int kind);
    if (err_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_error_pulse: got kind %0d expected none", kind);
    end else begin
      check("error_kind", 32'(kind), 32'(err_q.pop_front()));
    end
  endtask

  // Monitor: sample mid-cycle, pop expectations on handshakes and pulses
  initial begin
    prev_hold = 1'b0;
    prev_bits = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 32'(io_out_valid), 32'd1);
          check("hold_bits", 32'(io_out_bits), 32'(prev_bits));
        end
        if (io_out_valid && io_out_ready) begin
          if (word_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got 0x%0h expected none", io_out_bits);
          end else begin
            check("word", 32'(io_out_bits), 32'(word_q.pop_front()));
          end
        end
        if (io_parity_err) take_err(K_PERR);
        if (io_frame_err)  take_err(K_FERR);
        if (io_overrun)    take_err(K_OVR);
        prev_hold = io_out_valid && !io_out_ready;
        prev_bits = io_out_bits;
      end
    end
  end

  // One clock edge of stimulus; model the output register at frame level
  task automatic step(input bit b, input bit r, input int kind, input logic [7:0] d,
                      input bit exp_busy);
    bit load;
    io_in        = b;
    io_out_ready = r;
    @(posedge clock);
    #1;
    load = 1'b0;
    if (kind == K_GOOD) begin
      if (!held || r) begin
        word_q.push_back(d);
        held = 1'b1;
        load = 1'b1;
      end else begin
        err_q.push_back(K_OVR);
      end
    end else if (kind == K_PERR || kind == K_FERR) begin
      err_q.push_back(kind);
    end
    if (!load && held && r) held = 1'b0;
    check("busy", 32'(io_busy), 32'(exp_busy));
  endtask

  function automatic bit pick_rdy(input int mode, input bit is_stop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return is_stop;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_b, input int mode);
    int kind;
    kind = !stop_b ? K_FERR : (flip ? K_PERR : K_GOOD);
    step(1'b0, pick_rdy(mode, 1'b0), K_NONE, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(d[i], pick_rdy(mode, 1'b0), K_NONE, 8'h00, 1'b1);
    step((^d) ^ flip, pick_rdy(mode, 1'b0), K_NONE, 8'h00, 1'b1);
    step(stop_b, pick_rdy(mode, 1'b1), kind, d, 1'b0);
  endtask

  task automatic drain();
    repeat (3) step(1'b1, 1'b1, K_NONE, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic seq5 [7];
    logic [7:0] d;
    bit flip, stop_b;
    int r;

    n_chk  = 0;
    n_pass = 0;
    held   = 1'b0;
    reset  = 1'b0;
    io_in  = 1'b1;
    io_out_ready = 1'b0;
    line5  = 1'b1;
    ready5 = 1'b0;
    seq5   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_bits", 32'(io_out_bits), 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_errs", 32'({io_parity_err, io_frame_err, io_overrun}), 32'd0);
    check("rst_valid5", 32'(valid5), 32'd0);
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b0, K_NONE, 8'h00, 1'b0);

    // 0xA5 good, then drained
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_valid", 32'(io_out_valid), 32'd1);
    check("a5_bits", 32'(io_out_bits), 32'hA5);
    step(1'b1, 1'b1, K_NONE, 8'h00, 1'b0);
    check("a5_drained", 32'(io_out_valid), 32'd0);

    // 0xA5 with wrong parity
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, K_NONE, 8'h00, 1'b0);
    check("perr_no_valid", 32'(io_out_valid), 32'd0);

    // framing error, line held low, then recovery with 0x5A
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    repeat (3) step(1'b0, 1'b1, K_NONE, 8'h00, 1'b0);
    step(1'b1, 1'b1, K_NONE, 8'h00, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    check("5a_bits", 32'(io_out_bits), 32'h5A);
    drain();

    // back-to-back with ready low: overrun, 0x01 kept
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h02, 1'b0, 1'b1, 0);
    check("ovr_keep_bits", 32'(io_out_bits), 32'h01);
    drain();

    // back-to-back with ready exactly on second stop edge: refill
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h02, 1'b0, 1'b1, 3);
    check("refill_bits", 32'(io_out_bits), 32'h02);
    check("refill_valid", 32'(io_out_valid), 32'd1);
    drain();

    // randomized frames
    for (int n = 0; n < 60; n++) begin
      d      = 8'($urandom);
      r      = int'($urandom_range(0, 9));
      flip   = (r == 0);
      stop_b = (r != 1);
      send_frame(d, flip, stop_b, int'($urandom_range(0, 2)));
      if (!stop_b) begin
        repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), K_NONE, 8'h00, 1'b0);
        step(1'b1, 1'($urandom_range(0, 1)), K_NONE, 8'h00, 1'b0);
      end
      repeat ($urandom_range(0, 2)) step(1'b1, 1'($urandom_range(0, 1)), K_NONE, 8'h00, 1'b0);
    end
    drain();
    check("words_left", 32'(word_q.size()), 32'd0);
    check("errs_left", 32'(err_q.size()), 32'd0);

    // reset in the middle of a frame
    step(1'b0, 1'b0, K_NONE, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'(i), 1'b0, K_NONE, 8'h00, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(io_busy), 32'd0);
    check("midrst_valid", 32'(io_out_valid), 32'd0);
    word_q.delete();
    err_q.delete();
    held = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, K_NONE, 8'h00, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b1, 0);
    check("7e_bits", 32'(io_out_bits), 32'h7E);
    check("7e_valid", 32'(io_out_valid), 32'd1);
    drain();

    // DATA_W=5, no parity
    for (int i = 0; i < 7; i++) begin
      line5 = seq5[i];
      @(posedge clock);
      #1;
      if (i == 5) check("w5_not_yet", 32'(valid5), 32'd0);
    end
    check("w5_valid", 32'(valid5), 32'd1);
    check("w5_bits", 32'(bits5), 32'h13);
    check("w5_errs", 32'({perr5, ferr5, ovr5}), 32'd0);
    line5 = 1'b1;
    drain();

    check("final_words_left", 32'(word_q.size()), 32'd0);
    check("final_errs_left", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
